// File: rtl/fwd_scoreboard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_scoreboard_unit
//  Description : Decode-side operand bypass network combined with a 32-entry
//                register scoreboard for long-latency producers. Generates
//                forwarded operands, stall/issue, and a saturating stall
//                counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_scoreboard_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_FWD    = 3,
  parameter int LAT_WIDTH  = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_dec_valid,
  input  logic                          i_ex_stall,
  input  logic                          i_flush,
  input  logic                          i_uses_rs,
  input  logic                          i_uses_rt,
  input  logic [4:0]                    i_rs_addr,
  input  logic [4:0]                    i_rt_addr,
  input  logic [DATA_WIDTH-1:0]         i_rs_rf_data,
  input  logic [DATA_WIDTH-1:0]         i_rt_rf_data,
  input  logic                          i_writes,
  input  logic [4:0]                    i_rw_addr,
  input  logic [LAT_WIDTH-1:0]          i_lat,
  input  logic [NUM_FWD-1:0]            i_fwd_valid,
  input  logic [5*NUM_FWD-1:0]          i_fwd_addr,
  input  logic [DATA_WIDTH*NUM_FWD-1:0] i_fwd_data,
  input  logic                          i_ll_done,
  input  logic [4:0]                    i_ll_addr,
  input  logic [DATA_WIDTH-1:0]         i_ll_data,
  output logic [DATA_WIDTH-1:0]         o_rs_data,
  output logic [DATA_WIDTH-1:0]         o_rt_data,
  output logic                          o_stall,
  output logic                          o_issue,
  output logic [31:0]                   o_busy,
  output logic [31:0]                   o_stall_count
);

  localparam logic [31:0] c_CNT_MAX = 32'hFFFF_FFFF;

  logic [31:0] busy_q, busy_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic                  w_rs_hit, w_rt_hit;
  logic [DATA_WIDTH-1:0] w_rs_sel, w_rt_sel;
  logic                  w_rs_ok, w_rt_ok, w_waw, w_stall, w_issue;

  // Bypass lookup: returns {hit, data}. Scanning from the oldest source down
  // to index 0 lets the youngest matching source overwrite older ones, and the
  // completing long-latency result sits below every bypass source.
  function automatic logic [DATA_WIDTH:0] fwd_pick(input logic [4:0] addr,
                                                   input logic [DATA_WIDTH-1:0] rf);
    logic [DATA_WIDTH:0] r;
    r = {1'b0, rf};
    if (i_ll_done && (i_ll_addr == addr)) r = {1'b1, i_ll_data};
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (i_fwd_valid[k] && (i_fwd_addr[5*k +: 5] == addr))
        r = {1'b1, i_fwd_data[DATA_WIDTH*k +: DATA_WIDTH]};
    end
    return r;
  endfunction

  // Operand selection: unused operands pass RF data, $0 always reads as zero.
  always_comb begin
    {w_rs_hit, w_rs_sel} = fwd_pick(i_rs_addr, i_rs_rf_data);
    {w_rt_hit, w_rt_sel} = fwd_pick(i_rt_addr, i_rt_rf_data);
    o_rs_data = w_rs_sel;
    o_rt_data = w_rt_sel;
    if (!i_uses_rs)             o_rs_data = i_rs_rf_data;
    else if (i_rs_addr == 5'd0) o_rs_data = '0;
    if (!i_uses_rt)             o_rt_data = i_rt_rf_data;
    else if (i_rt_addr == 5'd0) o_rt_data = '0;
  end

  // Hazard detection: RAW on unresolvable operands plus WAW on busy targets.
  always_comb begin
    w_rs_ok = !i_uses_rs || (i_rs_addr == 5'd0) || !busy_q[i_rs_addr] || w_rs_hit;
    w_rt_ok = !i_uses_rt || (i_rt_addr == 5'd0) || !busy_q[i_rt_addr] || w_rt_hit;
    w_waw   = i_writes && (i_rw_addr != 5'd0) && busy_q[i_rw_addr] &&
              !(i_ll_done && (i_ll_addr == i_rw_addr));
    w_stall = i_dec_valid && !i_flush && (!w_rs_ok || !w_rt_ok || w_waw);
    w_issue = i_dec_valid && !i_flush && !w_stall && !i_ex_stall;
  end

  // Scoreboard next state: completion clears first so a same-cycle set wins.
  always_comb begin
    busy_d = busy_q;
    if (i_ll_done) busy_d[i_ll_addr] = 1'b0;
    if (w_issue && i_writes && (i_lat != '0) && (i_rw_addr != 5'd0))
      busy_d[i_rw_addr] = 1'b1;
    busy_d[0] = 1'b0;
    stall_cnt_d = stall_cnt_q;
    if (w_stall && (stall_cnt_q != c_CNT_MAX)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      busy_q      <= busy_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_stall       = w_stall;
  assign o_issue       = w_issue;
  assign o_busy        = busy_q;
  assign o_stall_count = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fwd_scoreboard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fwd_scoreboard_unit
//  Description : Self-checking bench for fwd_scoreboard_unit. Expected values
//                are queued as stimulus is applied and drained against the
//                DUT outputs between clock edges.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fwd_scoreboard_unit;

  localparam int DW = 32;
  localparam int NF = 3;
  localparam int LW = 3;

  localparam int c_SEL_RS    = 0;
  localparam int c_SEL_RT    = 1;
  localparam int c_SEL_STALL = 2;
  localparam int c_SEL_ISSUE = 3;
  localparam int c_SEL_BUSY  = 4;
  localparam int c_SEL_CNT   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_dec_valid, i_ex_stall, i_flush;
  logic            i_uses_rs, i_uses_rt;
  logic [4:0]      i_rs_addr, i_rt_addr;
  logic [DW-1:0]   i_rs_rf_data, i_rt_rf_data;
  logic            i_writes;
  logic [4:0]      i_rw_addr;
  logic [LW-1:0]   i_lat;
  logic [NF-1:0]   i_fwd_valid;
  logic [5*NF-1:0] i_fwd_addr;
  logic [DW*NF-1:0] i_fwd_data;
  logic            i_ll_done;
  logic [4:0]      i_ll_addr;
  logic [DW-1:0]   i_ll_data;
  logic [DW-1:0]   o_rs_data, o_rt_data;
  logic            o_stall, o_issue;
  logic [31:0]     o_busy, o_stall_count;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  fwd_scoreboard_unit #(.DATA_WIDTH(DW), .NUM_FWD(NF), .LAT_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .i_dec_valid(i_dec_valid), .i_ex_stall(i_ex_stall), .i_flush(i_flush),
    .i_uses_rs(i_uses_rs), .i_uses_rt(i_uses_rt),
    .i_rs_addr(i_rs_addr), .i_rt_addr(i_rt_addr),
    .i_rs_rf_data(i_rs_rf_data), .i_rt_rf_data(i_rt_rf_data),
    .i_writes(i_writes), .i_rw_addr(i_rw_addr), .i_lat(i_lat),
    .i_fwd_valid(i_fwd_valid), .i_fwd_addr(i_fwd_addr), .i_fwd_data(i_fwd_data),
    .i_ll_done(i_ll_done), .i_ll_addr(i_ll_addr), .i_ll_data(i_ll_data),
    .o_rs_data(o_rs_data), .o_rt_data(o_rt_data),
    .o_stall(o_stall), .o_issue(o_issue),
    .o_busy(o_busy), .o_stall_count(o_stall_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      c_SEL_RS:    return o_rs_data;
      c_SEL_RT:    return o_rt_data;
      c_SEL_STALL: return {31'd0, o_stall};
      c_SEL_ISSUE: return {31'd0, o_issue};
      c_SEL_BUSY:  return o_busy;
      default:     return o_stall_count;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = exp;
    exp_q.push_back(e);
  endtask

  // Let combinational outputs settle, then compare every queued expectation.
  task automatic drain;
    exp_t e;
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic idle_inputs;
    i_dec_valid = 0; i_ex_stall = 0; i_flush = 0;
    i_uses_rs = 0; i_uses_rt = 0; i_rs_addr = 0; i_rt_addr = 0;
    i_rs_rf_data = 0; i_rt_rf_data = 0;
    i_writes = 0; i_rw_addr = 0; i_lat = 0;
    i_fwd_valid = 0; i_fwd_addr = 0; i_fwd_data = 0;
    i_ll_done = 0; i_ll_addr = 0; i_ll_data = 0;
  endtask

  task automatic next_cycle;
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;

    // Reset state
    expect_val("rst_busy", c_SEL_BUSY, 32'h0);
    expect_val("rst_cnt", c_SEL_CNT, 32'h0);
    expect_val("rst_stall", c_SEL_STALL, 32'h0);
    drain();

    // lw $5 with latency 2 issues
    i_dec_valid = 1; i_writes = 1; i_rw_addr = 5; i_lat = 2;
    expect_val("lw5_issue", c_SEL_ISSUE, 32'h1);
    expect_val("lw5_stall", c_SEL_STALL, 32'h0);
    drain();
    next_cycle();

    // add reads $5 with no bypass: stalls two cycles
    i_uses_rs = 1; i_rs_addr = 5; i_rs_rf_data = 32'h1234_5678;
    i_uses_rt = 1; i_rt_addr = 6; i_rt_rf_data = 32'h6666_6666;
    i_rw_addr = 10; i_lat = 0;
    expect_val("busy5_set", c_SEL_BUSY, 32'h0000_0020);
    expect_val("raw_stall", c_SEL_STALL, 32'h1);
    expect_val("raw_issue", c_SEL_ISSUE, 32'h0);
    expect_val("raw_cnt0", c_SEL_CNT, 32'd0);
    drain();
    next_cycle();
    expect_val("raw_cnt1", c_SEL_CNT, 32'd1);
    expect_val("raw_stall2", c_SEL_STALL, 32'h1);
    drain();
    next_cycle();

    // Completion of $5 resolves the operand in the same cycle
    i_ll_done = 1; i_ll_addr = 5; i_ll_data = 32'hDEAD_BEEF;
    expect_val("ll_cnt2", c_SEL_CNT, 32'd2);
    expect_val("ll_stall", c_SEL_STALL, 32'h0);
    expect_val("ll_rs", c_SEL_RS, 32'hDEAD_BEEF);
    expect_val("ll_rt_rf", c_SEL_RT, 32'h6666_6666);
    expect_val("ll_issue", c_SEL_ISSUE, 32'h1);
    drain();
    next_cycle();
    idle_inputs();
    expect_val("busy5_clr", c_SEL_BUSY, 32'h0);
    drain();

    // Bypass priority on rt=$7: sources 0 and 2 match
    i_uses_rt = 1; i_rt_addr = 7; i_rt_rf_data = 32'h33;
    i_fwd_addr = {5'd7, 5'd3, 5'd7};
    i_fwd_data = {32'h22, 32'h44, 32'h11};
    i_fwd_valid = 3'b101;
    expect_val("fwd_k0", c_SEL_RT, 32'h11);
    drain();
    i_fwd_valid = 3'b100;
    expect_val("fwd_k2", c_SEL_RT, 32'h22);
    drain();
    i_fwd_valid = 3'b000;
    expect_val("fwd_rf", c_SEL_RT, 32'h33);
    drain();
    // Unused operand passes RF data even with a matching source
    i_fwd_valid = 3'b001; i_uses_rt = 0;
    expect_val("unused_rf", c_SEL_RT, 32'h33);
    drain();
    idle_inputs();

    // $0 never forwarded and never marked busy
    i_uses_rs = 1; i_rs_addr = 0; i_rs_rf_data = 32'h99;
    i_fwd_valid = 3'b001; i_fwd_addr = {5'd1, 5'd1, 5'd0}; i_fwd_data = {32'h0, 32'h0, 32'h55};
    expect_val("r0_zero", c_SEL_RS, 32'h0);
    drain();
    idle_inputs();
    i_dec_valid = 1; i_writes = 1; i_rw_addr = 0; i_lat = 2;
    expect_val("lw0_issue", c_SEL_ISSUE, 32'h1);
    drain();
    next_cycle();
    idle_inputs();
    expect_val("lw0_busy", c_SEL_BUSY, 32'h0);
    drain();

    // WAW on $9
    i_dec_valid = 1; i_writes = 1; i_rw_addr = 9; i_lat = 3;
    drain();
    next_cycle();
    i_lat = 0;
    expect_val("busy9_set", c_SEL_BUSY, 32'h0000_0200);
    expect_val("waw_stall", c_SEL_STALL, 32'h1);
    expect_val("waw_issue", c_SEL_ISSUE, 32'h0);
    drain();
    next_cycle();
    i_ll_done = 1; i_ll_addr = 9; i_lat = 3;
    expect_val("waw_cnt", c_SEL_CNT, 32'd3);
    expect_val("waw_ll_stall", c_SEL_STALL, 32'h0);
    expect_val("waw_ll_issue", c_SEL_ISSUE, 32'h1);
    drain();
    next_cycle();
    idle_inputs();
    expect_val("set_wins", c_SEL_BUSY, 32'h0000_0200);
    drain();

    // Downstream stall blocks issue without raising o_stall
    i_dec_valid = 1; i_ex_stall = 1; i_uses_rs = 1; i_rs_addr = 4;
    expect_val("exst_stall", c_SEL_STALL, 32'h0);
    expect_val("exst_issue", c_SEL_ISSUE, 32'h0);
    drain();
    next_cycle();
    idle_inputs();

    // Flush masks a RAW stall; busy untouched
    i_dec_valid = 1; i_flush = 1; i_uses_rs = 1; i_rs_addr = 9;
    i_writes = 1; i_rw_addr = 12; i_lat = 2;
    expect_val("flush_stall", c_SEL_STALL, 32'h0);
    expect_val("flush_issue", c_SEL_ISSUE, 32'h0);
    drain();
    next_cycle();
    i_flush = 0; i_writes = 0;
    expect_val("flush_busy", c_SEL_BUSY, 32'h0000_0200);
    expect_val("flush_cnt", c_SEL_CNT, 32'd3);
    expect_val("unflush_stall", c_SEL_STALL, 32'h1);
    drain();

    // Saturation: preload the counter near its ceiling
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt_q;
    next_cycle();
    expect_val("sat_fe", c_SEL_CNT, 32'hFFFF_FFFE);
    drain();
    next_cycle();
    expect_val("sat_ff", c_SEL_CNT, 32'hFFFF_FFFF);
    drain();
    next_cycle();
    expect_val("sat_hold", c_SEL_CNT, 32'hFFFF_FFFF);
    drain();

    // Reset during a stall clears everything on the next edge
    rst = 1;
    next_cycle();
    rst = 0;
    expect_val("rst2_busy", c_SEL_BUSY, 32'h0);
    expect_val("rst2_cnt", c_SEL_CNT, 32'h0);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fwd_scoreboard_unit.md
Name: fwd_scoreboard_unit

Overview:
Parametrised successor to the combinational forwarding unit. Combines an N-source bypass network with a 32-entry register scoreboard that tracks in-flight long-latency producers (loads, multi-cycle ops), so hazard detection is no longer limited to one-cycle load-use. Sits beside decode. Produces forwarded rs/rt operands, a stall, and an issue strobe into EX, and keeps a saturating stall-cycle performance counter.

Parameters:
DATA_WIDTH, 32, operand width
NUM_FWD, 3, number of bypass sources; index 0 is youngest and has the highest priority
LAT_WIDTH, 3, width of the issue-latency field

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
i_dec_valid  in  1  decode holds a valid instruction
i_ex_stall  in  1  downstream cannot accept an instruction this cycle
i_flush  in  1  kill the decode instruction this cycle
i_uses_rs / i_uses_rt  in  1 each  operand used
i_rs_addr / i_rt_addr  in  5 each  source registers
i_rs_rf_data / i_rt_rf_data  in  DATA_WIDTH each  register-file read data
i_writes  in  1  decode instruction writes a register
i_rw_addr  in  5  destination register
i_lat  in  LAT_WIDTH  0 = result forwardable from the bypass network; >0 = long-latency, tracked by scoreboard
i_fwd_valid  in  NUM_FWD  bypass source valid
i_fwd_addr  in  5*NUM_FWD  bypass destinations, packed, source k at [5k+4:5k]
i_fwd_data  in  DATA_WIDTH*NUM_FWD  bypass data, packed
i_ll_done  in  1  long-latency result completes this cycle
i_ll_addr  in  5  completing register
i_ll_data  in  DATA_WIDTH  completing data
o_rs_data / o_rt_data  out  DATA_WIDTH each  forwarded operands
o_stall  out  1  decode must hold
o_issue  out  1  instruction advances to EX this cycle
o_busy  out  32  scoreboard busy vector, registered
o_stall_count  out  32  saturating stall-cycle counter

Behaviour:
- Reset (synchronous) clears busy[31:0] and o_stall_count to 0.
- Register $0 is never marked busy and is never forwarded. Any read of $0 returns 0 regardless of RF data.
- Operand mux (combinational), per operand, highest priority first:
  - lowest index k with i_fwd_valid[k] and address match;
  - else i_ll_done with address match → i_ll_data;
  - else RF data.
  - If the operand is not used, pass RF data through.
- An operand is "resolvable" if it is unused, is $0, is not busy, or is matched this cycle by a valid bypass source or by i_ll_done.
- o_stall = i_dec_valid & ~i_flush & (any used operand is not resolvable, OR a WAW hazard exists).
  - WAW hazard: i_writes, i_rw_addr != 0, busy[i_rw_addr], and no i_ll_done to i_rw_addr this cycle.
- o_issue = i_dec_valid & ~i_flush & ~o_stall & ~i_ex_stall.
- Scoreboard update at the clock edge:
  - i_ll_done clears busy[i_ll_addr];
  - then o_issue & i_writes & (i_lat != 0) & (i_rw_addr != 0) sets busy[i_rw_addr].
  - When both target the same register in one cycle, set wins.
  - i_ll_done to a register that is not busy has no effect and is not an error.
- i_flush suppresses issue and stall only; busy bits are untouched, because producers already past decode still complete.
- i_ex_stall does not assert o_stall; it only blocks o_issue.
- o_stall_count increments every cycle o_stall = 1 and holds at 32'hFFFF_FFFF.
- Latency: operands and stall are combinational. Busy changes are visible the cycle after the edge.

Test Plan:
- Reset, then issue lw $5 (i_lat=2, writes) → o_busy[5]=1 next cycle. Next decode add uses rs=$5 with no bypass → o_stall=1, o_issue=0, o_stall_count increments each stalled cycle.
- With busy[5] set, i_ll_done=1, i_ll_addr=5, i_ll_data=32'hDEAD_BEEF while decode reads $5 → o_stall=0, o_rs_data=32'hDEAD_BEEF; next cycle o_busy[5]=0.
- fwd[0] and fwd[2] both valid for $7 with data 0x11 and 0x22; RF=0x33 → o_rt_data=0x11. Drop fwd[0] valid → 0x22. Drop both → 0x33.
- Decode reads $0 while fwd[0] targets $0 with 0x55 and RF returns 0x99 → o_rs_data=0. Issue lw $0 → o_busy stays 0.
- WAW: busy[9] set, decode writes $9 with i_lat=0 → o_stall=1. Same cycle with i_ll_done for $9 and i_lat=3 → o_issue=1, o_busy[9] stays 1 next cycle (set wins).
- Stall with i_flush=1 → o_stall=0, o_issue=0, busy unchanged. Force 2^32 stall cycles (preload via backdoor) → counter holds 32'hFFFF_FFFF. Assert rst mid-stall → busy and counter 0 on the next edge.
